// File: rtl/mips_reg_ctrl.sv
// Request/response front end for a MIPS-style 32x32 register file: paired reads,
// single writes with $zero suppression, and a scrub that zeroes r1..r31.
module mips_reg_ctrl #(
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic        ReqClear,
    input  logic [4:0]  ReqAddrA,
    input  logic [4:0]  ReqAddrB,
    input  logic [31:0] ReqData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspDataA,
    output logic [31:0] RspDataB,
    output logic [4:0]  ReadAddr1,
    output logic [4:0]  ReadAddr2,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    output logic        RegWrite,
    output logic        Busy
);

    typedef enum logic [2:0] {
        ST_SCRUB,
        ST_IDLE,
        ST_READ,
        ST_RESP,
        ST_WRITE
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_SCRUB : ST_IDLE;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_addr_q, write_addr_d;
    logic [31:0] write_data_q, write_data_d;
    logic [4:0]  read_addr1_q, read_addr1_d;
    logic [4:0]  read_addr2_q, read_addr2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_a_q, rsp_data_a_d;
    logic [31:0] rsp_data_b_q, rsp_data_b_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reg_write_d  = reg_write_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        read_addr1_d = read_addr1_q;
        read_addr2_d = read_addr2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_a_d = rsp_data_a_q;
        rsp_data_b_d = rsp_data_b_q;

        case (state_q)
            ST_SCRUB: begin
                // Write-port outputs are registered, so each SCRUB cycle presents the
                // address loaded on the previous edge. Straight out of reset nothing is
                // loaded yet, so the first cycle only primes address cnt_q.
                if (!reg_write_q) begin
                    reg_write_d  = 1'b1;
                    write_addr_d = cnt_q;
                    write_data_d = 32'd0;
                end else if (cnt_q == 5'd31) begin
                    reg_write_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d        = cnt_q + 5'd1;
                    reg_write_d  = 1'b1;
                    write_addr_d = cnt_q + 5'd1;
                    write_data_d = 32'd0;
                end
            end
            ST_IDLE: begin
                if (ReqValid) begin
                    if (ReqClear) begin
                        state_d      = ST_SCRUB;
                        cnt_d        = 5'd1;
                        reg_write_d  = 1'b1;
                        write_addr_d = 5'd1;
                        write_data_d = 32'd0;
                    end else if (ReqWrite) begin
                        state_d = ST_WRITE;
                        // A write to $zero leaves the whole write port untouched.
                        if (ReqAddrA != 5'd0) begin
                            reg_write_d  = 1'b1;
                            write_addr_d = ReqAddrA;
                            write_data_d = ReqData;
                        end
                    end else begin
                        state_d      = ST_READ;
                        read_addr1_d = ReqAddrA;
                        read_addr2_d = ReqAddrB;
                    end
                end
            end
            ST_READ: begin
                state_d      = ST_RESP;
                rsp_valid_d  = 1'b1;
                rsp_data_a_d = (read_addr1_q == 5'd0) ? 32'd0 : ReadData1;
                rsp_data_b_d = (read_addr2_q == 5'd0) ? 32'd0 : ReadData2;
            end
            ST_RESP: begin
                if (RspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_WRITE: begin
                reg_write_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= RESET_STATE;
            cnt_q        <= 5'd1;
            reg_write_q  <= 1'b0;
            write_addr_q <= 5'd0;
            write_data_q <= 32'd0;
            read_addr1_q <= 5'd0;
            read_addr2_q <= 5'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_a_q <= 32'd0;
            rsp_data_b_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            read_addr1_q <= read_addr1_d;
            read_addr2_q <= read_addr2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_a_q <= rsp_data_a_d;
            rsp_data_b_q <= rsp_data_b_d;
        end
    end

    assign ReqReady  = (state_q == ST_IDLE);
    assign Busy      = (state_q != ST_IDLE);
    assign RegWrite  = reg_write_q;
    assign WriteAddr = write_addr_q;
    assign WriteData = write_data_q;
    assign ReadAddr1 = read_addr1_q;
    assign ReadAddr2 = read_addr2_q;
    assign RspValid  = rsp_valid_q;
    assign RspDataA  = rsp_data_a_q;
    assign RspDataB  = rsp_data_b_q;

endmodule
